// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 fetch/queue stage.
//   - icode constants, status codes, REG_NONE
//   - fetch_entry_t: one decoded instruction as it sits in the fetch queue
//   - fetch_state_e: fetch control states
//   - instr_len / has_reg / has_valc: format helpers keyed on icode
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [3:0]  stat;
  } fetch_entry_t;

  // What decode sees whenever the queue is empty: a bubble NOP.
  localparam fetch_entry_t FETCH_IDLE = '{icode: I_NOP, ifun: 4'h0, rA: REG_NONE,
                                          rB: REG_NONE, valC: 64'd0, valP: 64'd0,
                                          stat: STAT_AOK};

  typedef enum logic [1:0] {ST_RUN, ST_WAIT_RET, ST_STOP} fetch_state_e;

  // Invalid icodes are treated as one byte long so the ADR check stays sane.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:               instr_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   instr_len = 4'd2;
      I_JXX, I_CALL:                      instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       instr_len = 4'd10;
      default:                            instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: has_reg = 1'b1;
      default: has_reg = 1'b0;
    endcase
  endfunction

  function automatic logic has_valc(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: has_valc = 1'b1;
      default: has_valc = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue_stage_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with synchronous flush.
//   clk, rst (async high)  - clock / reset (pointers and count only)
//   push, din              - write din when not full
//   pop                    - drop head when not empty
//   flush                  - empty the FIFO; overrides push and pop
//   dout                   - head entry (stale when empty)
//   count, empty           - occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: Y86-64 fetch with a decoupling queue toward decode.
//   clk, rst (async high)            - clock / reset
//   imem_we, imem_waddr, imem_wdata  - program load port (byte writes)
//   M_icode, M_cnd, M_valA           - mispredicted jXX redirect from memory stage
//   W_icode, W_valM                  - ret redirect from write-back
//   d_valid, d_ready                 - queue head handshake with decode
//   D_icode..D_stat                  - queue head fields (NOP bubble when empty)
// One instruction is fetched per cycle in RUN while the queue has room.
// Redirects flush the queue and restart at the target on the next cycle.
module fetch_queue_stage
  import y86_pkg::*;
#(
  parameter int          IMEM_BYTES = 256,
  parameter int          QDEPTH     = 4,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
  input  logic [7:0]                    imem_wdata,
  input  logic [3:0]                    M_icode,
  input  logic                          M_cnd,
  input  logic [63:0]                   M_valA,
  input  logic [3:0]                    W_icode,
  input  logic [63:0]                   W_valM,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [3:0]                    D_icode,
  output logic [3:0]                    D_ifun,
  output logic [3:0]                    D_rA,
  output logic [3:0]                    D_rB,
  output logic [63:0]                   D_valC,
  output logic [63:0]                   D_valP,
  output logic [3:0]                    D_stat
);
  localparam int          AW       = $clog2(IMEM_BYTES);
  localparam int          CW       = $clog2(QDEPTH) + 1;
  localparam int          EW       = $bits(fetch_entry_t);
  localparam logic [63:0] IMEM_LIM = 64'(IMEM_BYTES);

  logic [7:0]   imem [IMEM_BYTES];
  logic [7:0]   ib [10];
  logic [63:0]  pc, pc_end, next_pc, redir_pc;
  logic         pc_ok, adr, redirect, redir_ret, redir_jxx, fetch_en, q_full, q_empty;
  logic [3:0]   f_icode, f_ifun, f_len;
  logic [63:0]  f_valc;
  fetch_entry_t f_ent, q_head, head;
  logic [EW-1:0] q_dout;
  logic [CW-1:0] q_count;
  fetch_state_e state, state_nxt;

  // Program load; a same-cycle fetch sees the old byte.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // Up to 10 instruction bytes from PC; bytes past the end of memory read 0.
  for (genvar g = 0; g < 10; g++) begin : g_byte
    assign ib[g] = (pc + 64'(g) < IMEM_LIM) ? imem[AW'(pc + 64'(g))] : 8'h00;
  end

  always_comb begin
    pc_ok   = (pc < IMEM_LIM);
    f_icode = pc_ok ? ib[0][7:4] : I_HALT;
    f_ifun  = pc_ok ? ib[0][3:0] : 4'h0;
    f_len   = instr_len(f_icode);
    pc_end  = pc + 64'(f_len) - 64'd1;
    adr     = !pc_ok || (pc_end >= IMEM_LIM);
    f_valc  = 64'd0;
    if (has_valc(f_icode))
      f_valc = has_reg(f_icode) ? {ib[2], ib[3], ib[4], ib[5], ib[6], ib[7], ib[8], ib[9]}
                                : {ib[1], ib[2], ib[3], ib[4], ib[5], ib[6], ib[7], ib[8]};
    f_ent.icode = f_icode;
    f_ent.ifun  = f_ifun;
    f_ent.rA    = has_reg(f_icode) ? ib[1][7:4] : REG_NONE;
    f_ent.rB    = has_reg(f_icode) ? ib[1][3:0] : REG_NONE;
    f_ent.valC  = f_valc;
    f_ent.valP  = (adr || f_icode == I_HALT) ? pc : pc + 64'(f_len);
    if (adr)                   f_ent.stat = STAT_ADR;
    else if (f_icode > I_POPQ) f_ent.stat = STAT_INS;
    else if (f_icode == I_HALT) f_ent.stat = STAT_HLT;
    else                       f_ent.stat = STAT_AOK;
    next_pc = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_ent.valP;
  end

  // ret in write-back outranks a mispredicted jXX in memory.
  assign redir_ret = (W_icode == I_RET);
  assign redir_jxx = (M_icode == I_JXX) && !M_cnd;
  assign redirect  = redir_ret || redir_jxx;
  assign redir_pc  = redir_ret ? W_valM : M_valA;

  // Control FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Control FSM: next state
  always_comb begin
    state_nxt = state;
    if (redirect)
      state_nxt = ST_RUN;
    else if (fetch_en) begin
      if (f_ent.stat != STAT_AOK) state_nxt = ST_STOP;
      else if (f_icode == I_RET)  state_nxt = ST_WAIT_RET;
    end
  end

  // Control FSM: outputs. Full is judged on the pre-pop count.
  always_comb begin
    fetch_en = (state == ST_RUN) && !q_full && !redirect;
  end

  // PC only advances on a clean fetch; ret and faulting fetches hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= redir_pc;
    else if (fetch_en && f_ent.stat == STAT_AOK && f_icode != I_RET)
      pc <= next_pc;
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_en),
    .pop   (d_ready),
    .flush (redirect),
    .din   (f_ent),
    .dout  (q_dout),
    .count (q_count),
    .empty (q_empty)
  );

  assign q_full  = (q_count == CW'(QDEPTH));
  assign q_head  = q_dout;
  assign head    = q_empty ? FETCH_IDLE : q_head;
  assign d_valid = !q_empty;
  assign D_icode = head.icode;
  assign D_ifun  = head.ifun;
  assign D_rA    = head.rA;
  assign D_rB    = head.rB;
  assign D_valC  = head.valC;
  assign D_valP  = head.valP;
  assign D_stat  = head.stat;

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;
  import y86_pkg::*;

  localparam int          IMEM = 256;
  localparam int          QD   = 4;
  localparam logic [63:0] RPC  = 64'd0;

  logic        clk, rst, imem_we, M_cnd, d_valid, d_ready;
  logic [7:0]  imem_waddr, imem_wdata;
  logic [3:0]  M_icode, W_icode, D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] M_valA, W_valM, D_valC, D_valP;

  fetch_queue_stage #(.IMEM_BYTES(IMEM), .QDEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM), .d_valid(d_valid), .d_ready(d_ready),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_chk = 0, n_fail = 0;
  logic [7:0]   bmem [IMEM];
  logic [7:0]   img  [IMEM];
  fetch_entry_t mq[$];
  fetch_entry_t seen[$];
  logic [63:0]  mpc;
  int           mode;   // 0 fetching, 1 waiting for ret, 2 stopped
  int           LEN [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  localparam fetch_entry_t IDLE = '{icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF,
                                    valC: 64'd0, valP: 64'd0, stat: 4'd1};

  task automatic chk(input string nm, input logic [147:0] got, input logic [147:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [63:0] a);
    return (a < 64'(IMEM)) ? bmem[a[7:0]] : 8'h00;
  endfunction

  // Reference fetch: straight from the instruction-format rules.
  function automatic fetch_entry_t model_fetch(input logic [63:0] pc);
    fetch_entry_t e;
    logic [7:0]   b0, b1;
    int           len, voff;
    b0      = mb(pc);
    b1      = mb(pc + 64'd1);
    e.icode = (pc < 64'(IMEM)) ? b0[7:4] : 4'h0;
    e.ifun  = (pc < 64'(IMEM)) ? b0[3:0] : 4'h0;
    len     = LEN[e.icode];
    e.rA    = 4'hF;
    e.rB    = 4'hF;
    e.valC  = 64'd0;
    if (e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
      e.rA = b1[7:4];
      e.rB = b1[3:0];
    end
    voff = 0;
    if (e.icode inside {4'h3, 4'h4, 4'h5}) voff = 2;
    if (e.icode inside {4'h7, 4'h8})       voff = 1;
    if (voff != 0)
      for (int k = 0; k < 8; k++) e.valC = {e.valC[55:0], mb(pc + 64'(voff + k))};
    if (pc + 64'(len) - 64'd1 >= 64'(IMEM)) begin
      e.stat = 4'd3;
      e.valP = pc;
    end else begin
      e.valP = (e.icode == 4'h0) ? pc : pc + 64'(len);
      e.stat = (e.icode > 4'hB) ? 4'd4 : (e.icode == 4'h0) ? 4'd2 : 4'd1;
    end
    return e;
  endfunction

  function automatic fetch_entry_t seen_at(input int i);
    return (i < seen.size()) ? seen[i] : '1;
  endfunction

  // Monitor + reference model: compare the head each cycle, then predict the next edge.
  initial forever begin
    fetch_entry_t got, e;
    @(negedge clk);
    got = {D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat};
    if (rst) begin
      mq.delete();
      mpc  = RPC;
      mode = 0;
      chk("rst_valid", d_valid, 1'b0);
      chk("rst_head", got, IDLE);
    end else begin
      chk("d_valid", d_valid, mq.size() != 0);
      chk("head", got, (mq.size() != 0) ? mq[0] : IDLE);
      if (W_icode == 4'h9) begin
        mq.delete(); mpc = W_valM; mode = 0;
      end else if (M_icode == 4'h7 && !M_cnd) begin
        mq.delete(); mpc = M_valA; mode = 0;
      end else begin
        logic do_fetch;
        do_fetch = (mode == 0) && (mq.size() < QD);
        if (d_ready && mq.size() != 0) seen.push_back(mq.pop_front());
        if (do_fetch) begin
          e = model_fetch(mpc);
          mq.push_back(e);
          if (e.stat != 4'd1)      mode = 2;
          else if (e.icode == 4'h9) mode = 1;
          else if (e.icode == 4'h7 || e.icode == 4'h8) mpc = e.valC;
          else mpc = e.valP;
        end
      end
    end
    if (imem_we) bmem[imem_waddr] = imem_wdata;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input logic [7:0] b);
    for (int a = 0; a < IMEM; a++) img[a] = b;
  endtask

  task automatic load_image();
    rst = 1'b1; d_ready = 1'b0; M_icode = 4'h0; M_cnd = 1'b0; W_icode = 4'h0;
    for (int a = 0; a < IMEM; a++) begin
      imem_we = 1'b1; imem_waddr = 8'(a); imem_wdata = img[a];
      step(1);
    end
    imem_we = 1'b0;
    step(1);
    rst = 1'b0;
    seen.delete();
  endtask

  task automatic random_image();
    int pos, ic;
    int ICS [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 1, 6, 7, 0, 12};
    for (int a = 0; a < IMEM; a++) img[a] = 8'($urandom);
    pos = 0;
    while (pos < IMEM) begin
      ic = ICS[$urandom % 16];
      img[pos] = {4'(ic), 4'($urandom_range(0, 6))};
      pos += LEN[ic];
      if ((ic == 7 || ic == 8) && pos <= IMEM) begin
        for (int k = pos - 8; k < pos - 1; k++) img[k] = 8'h00;
        img[pos - 1] = 8'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; d_ready = 1'b0;
    M_icode = 4'h0; M_cnd = 1'b0; M_valA = '0; W_icode = 4'h0; W_valM = '0;
    step(2);

    // irmovq / addq / halt
    fill_img(8'h00);
    img[0] = 8'h30; img[1] = 8'hF2; img[9] = 8'h02;
    img[10] = 8'h60; img[11] = 8'h23; img[12] = 8'h00;
    load_image();
    d_ready = 1'b1;
    step(20);
    chk("prog_count", seen.size(), 3);
    chk("prog_irmov", seen_at(0), {4'h3, 4'h0, 4'hF, 4'h2, 64'd2, 64'd10, 4'd1});
    chk("prog_opq",   seen_at(1), {4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'd12, 4'd1});
    chk("prog_halt",  seen_at(2), {4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd12, 4'd2});

    // backpressure: queue fills, then drains back-to-back
    fill_img(8'h10);
    load_image();
    step(10);
    chk("full_valid", d_valid, 1'b1);
    d_ready = 1'b1;
    step(4);
    chk("drain_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("drain_valP", seen_at(i).valP, 64'(i + 1));

    // mispredicted jXX flush
    fill_img(8'h10);
    img[0] = 8'h70; for (int k = 1; k < 8; k++) img[k] = 8'h00; img[8] = 8'h14;
    for (int k = 20; k < 26; k += 2) begin img[k] = 8'h60; img[k + 1] = 8'h11; end
    load_image();
    step(3);
    M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'd9;
    step(1);
    M_icode = 4'h0; d_ready = 1'b1;
    step(4);
    chk("jxx_count", seen.size(), 3);
    chk("jxx_first", seen_at(0), {4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd10, 4'd1});
    for (int i = 0; i < 3; i++) chk("jxx_no_opq", seen_at(i).icode, 4'h1);

    // call / ret wait
    fill_img(8'h10);
    img[0] = 8'h80; for (int k = 1; k < 8; k++) img[k] = 8'h00; img[8] = 8'h28;
    img[40] = 8'h90;
    load_image();
    d_ready = 1'b1;
    step(8);
    chk("ret_wait_count", seen.size(), 2);
    chk("ret_call", seen_at(0), {4'h8, 4'h0, 4'hF, 4'hF, 64'd40, 64'd9, 4'd1});
    chk("ret_ret",  seen_at(1), {4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd41, 4'd1});
    W_icode = 4'h9; W_valM = 64'd9;
    step(1);
    W_icode = 4'h0;
    step(3);
    chk("ret_resume", seen_at(2).valP, 64'd10);

    // invalid instruction
    fill_img(8'h10);
    img[5] = 8'hC0;
    load_image();
    d_ready = 1'b1;
    step(12);
    chk("ins_count", seen.size(), 6);
    chk("ins_stat", seen_at(5).stat, 4'd4);
    chk("ins_icode", seen_at(5).icode, 4'hC);

    // instruction running off the end of memory
    fill_img(8'h10);
    img[0] = 8'h70; for (int k = 1; k < 8; k++) img[k] = 8'h00; img[8] = 8'hFA;
    img[250] = 8'h30; img[251] = 8'hF0;
    load_image();
    d_ready = 1'b1;
    step(8);
    chk("adr_count", seen.size(), 2);
    chk("adr_stat", seen_at(1).stat, 4'd3);
    chk("adr_valP", seen_at(1).valP, 64'd250);
    chk("adr_icode", seen_at(1).icode, 4'h3);

    // asynchronous reset with entries queued
    fill_img(8'h10);
    load_image();
    step(3);
    chk("pre_rst_valid", d_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", d_valid, 1'b0);
    step(2);
    rst = 1'b0;
    seen.delete();
    d_ready = 1'b1;
    step(3);
    chk("post_rst_first", seen_at(0).valP, RPC + 64'd1);

    // randomized programs, redirects, backpressure and live memory writes
    for (int r = 0; r < 3; r++) begin
      random_image();
      load_image();
      for (int c = 0; c < 300; c++) begin
        int sel;
        d_ready = ($urandom % 4) != 0;
        sel = $urandom % 16;
        M_icode = 4'h0; W_icode = 4'h0; M_cnd = 1'b0;
        if (sel == 0) begin W_icode = 4'h9; W_valM = 64'($urandom_range(0, 259)); end
        else if (sel == 1) begin M_icode = 4'h7; M_valA = 64'($urandom_range(0, 259)); end
        else if (sel == 2) begin M_icode = 4'h7; M_cnd = 1'b1; M_valA = 64'($urandom); end
        imem_we = ($urandom % 8) == 0;
        imem_waddr = 8'($urandom); imem_wdata = 8'($urandom);
        step(1);
      end
      imem_we = 1'b0; M_icode = 4'h0; W_icode = 4'h0;
      step(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised Y86-64 fetch stage with a decoupling instruction queue between fetch and decode. Each cycle it reads one instruction from a byte-addressed instruction memory, splits it into fields and predicts the next PC. It pushes the decoded instruction into a QDEPTH-entry FIFO, and decode pops the FIFO through a valid/ready handshake. Redirects from memory (mispredicted jXX) and write-back (ret) flush the queue and restart fetch at the corrected PC.

## Interface
- IMEM_BYTES, 256: instruction memory size in bytes.
- QDEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC loaded on reset.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_we  in  1  program-load write enable.
- imem_waddr  in  $clog2(IMEM_BYTES)  write byte address.
- imem_wdata  in  8  write byte.
- M_icode  in  4  icode in memory stage.
- M_cnd  in  1  branch condition in memory stage.
- M_valA  in  64  fall-through PC of the jXX in memory stage.
- W_icode  in  4  icode in write-back stage.
- W_valM  in  64  return address read by ret.
- d_valid  out  1  queue head holds an instruction.
- d_ready  in  1  decode accepts the head this cycle.
- D_icode, D_ifun, D_rA, D_rB  out  4 each  head fields.
- D_valC  out  64  head constant word.
- D_valP  out  64  head fall-through PC.
- D_stat  out  4  head status: AOK=1, HLT=2, ADR=3, INS=4.

## Operation
- Redirect sources, in priority order:
  - W_icode==RET selects target W_valM.
  - M_icode==JXX with !M_cnd selects target M_valA.
- On a redirect: PC ← target, queue emptied, state ← RUN. Any fetch and any pop in that cycle are discarded.
- States:
  - RUN fetches at PC when count<QDEPTH. A push and a pop may occur in the same cycle, but a push is never allowed when the pre-pop count equals QDEPTH.
  - WAIT_RET: entered after a RET is pushed; no fetch until a redirect.
  - STOP: entered after a HLT, ADR or INS entry is pushed; no fetch until a redirect or reset.
- Instruction lengths by icode:
  - 1 byte: HALT(0), NOP(1), RET(9).
  - 2 bytes: RRMOV/CMOV(2), OPQ(6), PUSH(A), POP(B).
  - 9 bytes: JXX(7), CALL(8).
  - 10 bytes: IRMOV(3), RMMOV(4), MRMOV(5).
- Fields: byte0 = {icode,ifun}. The register byte, when present, is {rA,rB}; otherwise rA=rB=0xF. valC occupies the remaining 8 bytes, most-significant byte first, and is 0 for formats without it.
- valP = PC+len. HALT is the exception: valP=PC.
- Next PC:
  - JXX and CALL: valC.
  - RET: held, and the stage enters WAIT_RET.
  - Otherwise: valP.
- Status:
  - ADR if PC+len-1 ≥ IMEM_BYTES. If PC itself is out of range, icode=ifun=0. Either way valP=PC.
  - Else INS if icode>0xB.
  - Else HLT if icode==0.
  - Else AOK.
- ADR takes precedence over INS and HLT.
- PC arithmetic is 64-bit, with wrap ignored because any address above IMEM_BYTES yields ADR.
- Memory writes take effect at the edge. A fetch in the same cycle reads the pre-write data. The memory array is not reset.

## Timing
- Reset (asynchronous): PC=RESET_PC, count=0, state RUN, d_valid=0. D_icode=1 (NOP), D_ifun=0, D_rA=D_rB=0xF, D_valC=0, D_valP=0, D_stat=AOK. These D_* values appear whenever the queue is empty.
- Reset asserted mid-operation discards all queued entries immediately.
- Fetch-to-decode latency: an instruction fetched in cycle N is pushed at edge N and visible with d_valid=1 in cycle N+1.
- The D_* outputs are driven from the head register (first-word fall-through) and are stable while d_valid && !d_ready.
- Redirect latency:
  - Redirect in cycle N: queue empty and PC=target after edge N.
  - First new instruction visible in cycle N+2.
- Full queue: fetch holds PC. Throughput is one instruction per cycle whenever d_ready stays high.

## Structure
- Package y86_pkg holds:
  - icode constants (HALT…POPQ);
  - the STAT_AOK/HLT/ADR/INS codes;
  - the REG_NONE=0xF constant;
  - the fetch_entry_t packed struct (icode, ifun, rA, rB, valC, valP, stat; 148 bits);
  - the function instr_len(icode).
- Sub-module sync_fifo, parametrised on WIDTH and DEPTH, provides push/pop, count, head output and flush. The top level contains the imem, PC register, field extraction and state machine.

## Test plan
- Load 30 F2 00…02 (irmovq, valC=2) at 0, then 60 23 at 10, then 00 at 12; d_ready=1.
  - Required entries in order:
    - {3,0,F,2,2,valP=10}
    - {6,0,2,3,0,valP=12}
    - {0,…,valP=12,HLT}
  - After the HLT entry, no further pushes.
- Hold d_ready=0 for 10 cycles after reset on a stream of NOPs: count saturates at QDEPTH and d_valid stays high. On release, QDEPTH entries drain back-to-back with PCs 0,1,2,3.
- jXX at 0 with valC=20, fall-through valP=9, then M_icode=7, M_cnd=0, M_valA=9:
  - the queue flushes;
  - the next entry has valP computed from PC=9;
  - nothing fetched from 20 survives.
- call to 40 where 40 holds 90 (ret):
  - fetch stalls in WAIT_RET;
  - W_icode=9 with W_valM=9 resumes fetch at 9 in the following cycle.
- Byte 0xC0 at PC 5 yields an INS entry and then STOP. A 10-byte instruction at 250 with IMEM_BYTES=256 yields ADR with valP=250.
- Assert rst while 3 entries are queued: d_valid drops without waiting for a clock edge. After release, the first entry has PC=RESET_PC.
